// File: rtl/and_reduce_pkg.sv
// Shared types and elaboration helpers for the AND-reduction sequencer.
package and_reduce_pkg;

    // Width of the beat counter and of the reported beat count.
    localparam int unsigned BEAT_W = 4;

    // Number of operand slots held per job (operands a..h).
    localparam int unsigned SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Beats needed to sweep all slots with a given lane count.
    function automatic int unsigned beats_of(input int unsigned port_num);
        return (port_num == 0) ? 0 : SLOTS / port_num;
    endfunction

    // Lane counts that divide the slot count evenly.
    function automatic bit port_num_legal(input int unsigned port_num);
        return (port_num == 1) || (port_num == 2) || (port_num == 4) || (port_num == 8);
    endfunction

endpackage

// File: rtl/and_reduce_sequencer_if.sv
// Job/result handshake bundle for the AND-reduction sequencer.
// master: operand producer + result consumer; slave: the sequencer.
interface and_reduce_sequencer_if
    import and_reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  c;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  e;
    logic [WIDTH-1:0]  f;
    logic [WIDTH-1:0]  g;
    logic [WIDTH-1:0]  h;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  q;
    logic              busy;
    logic [BEAT_W-1:0] beats;

    modport master (
        output in_valid, a, b, c, d, e, f, g, h, out_ready,
        input  in_ready, out_valid, q, busy, beats
    );

    modport slave (
        input  in_valid, a, b, c, d, e, f, g, h, out_ready,
        output in_ready, out_valid, q, busy, beats
    );

endinterface

// File: rtl/and_reduce_lanes.sv
// One reduction slice: AND of every bit across PORT_NUM operands.
module and_reduce_lanes #(
    parameter int unsigned PORT_NUM = 2,
    parameter int unsigned WIDTH    = 8
) (
    input  logic [PORT_NUM*WIDTH-1:0] slice,
    output logic                      all_ones
);

    // Reduce the whole flattened slice to one bit.
    always_comb begin
        all_ones = &slice;
    end

endmodule

// File: rtl/and_reduce_sequencer.sv
// Multi-cycle AND-reduction controller: captures a..h, sweeps them through
// one PORT_NUM-lane slice per beat and returns the reduced bit in q[0].
// Optional feature macro: AND_REDUCE_EARLY_EXIT_EN (finish on first zero beat).
module and_reduce_sequencer
    import and_reduce_pkg::*;
#(
    parameter int unsigned PORT_NUM = 2,
    parameter int unsigned WIDTH    = 8
) (
    input logic                   clk,
    input logic                   rst,
    and_reduce_sequencer_if.slave bus
);

    generate
        if (!port_num_legal(PORT_NUM) || (WIDTH < 1)) begin : g_bad_cfg
            $error("and_reduce_sequencer: PORT_NUM must be 1, 2, 4 or 8 and WIDTH >= 1");
        end
    endgenerate

    localparam int unsigned          BEATS    = beats_of(PORT_NUM);
    localparam logic [BEAT_W-1:0]    LAST_CNT = BEAT_W'(BEATS - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [WIDTH-1:0]          slot [SLOTS];
    logic [BEAT_W-1:0]         cnt;
    logic [BEAT_W-1:0]         beats_r;
    logic [WIDTH-1:0]          q_r;
    logic                      acc;
    logic                      acc_nxt;
    logic                      lane_and;
    logic                      finish;
    logic [PORT_NUM*WIDTH-1:0] slice;

    // Select the PORT_NUM slots addressed by the current beat.
    always_comb begin
        slice = '0;
        for (int unsigned lane = 0; lane < PORT_NUM; lane++) begin
            slice[lane*WIDTH +: WIDTH] = slot[3'(32'(cnt) * PORT_NUM + lane)];
        end
    end

    and_reduce_lanes #(
        .PORT_NUM (PORT_NUM),
        .WIDTH    (WIDTH)
    ) u_lanes (
        .slice    (slice),
        .all_ones (lane_and)
    );

    // Accumulator update and end-of-job detection for the current beat.
    always_comb begin
        acc_nxt = acc & lane_and;
        finish  = (cnt == LAST_CNT);
`ifdef AND_REDUCE_EARLY_EXIT_EN
        finish  = finish | ~acc_nxt;
`endif
    end

    // Next state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered result fields.
    always_comb begin
        bus.q     = q_r;
        bus.beats = beats_r;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, per-beat accumulation and result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slot[i] <= '0;
            end
            acc     <= 1'b1;
            cnt     <= '0;
            q_r     <= '0;
            beats_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        slot[0] <= bus.a;
                        slot[1] <= bus.b;
                        slot[2] <= bus.c;
                        slot[3] <= bus.d;
                        slot[4] <= bus.e;
                        slot[5] <= bus.f;
                        slot[6] <= bus.g;
                        slot[7] <= bus.h;
                        acc     <= 1'b1;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        q_r     <= WIDTH'(acc_nxt);
                        beats_r <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_reduce_sequencer.sv
// Scoreboard bench for and_reduce_sequencer in three configurations:
// u0 PORT_NUM=2/WIDTH=7, u1 PORT_NUM=8/WIDTH=7, u2 PORT_NUM=1/WIDTH=1.
module tb_and_reduce_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

`ifdef AND_REDUCE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef logic [6:0] ops_t [8];
    typedef struct {
        int q;
        int beats;
        int k;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    int   acc1[$];
    bit   ov_prev [3];
    bit   post_hs [3];

    and_reduce_sequencer_if #(.WIDTH(7)) i0 ();
    and_reduce_sequencer_if #(.WIDTH(7)) i1 ();
    and_reduce_sequencer_if #(.WIDTH(1)) i2 ();

    and_reduce_sequencer #(.PORT_NUM(2), .WIDTH(7)) u0 (.clk(clk), .rst(rst), .bus(i0));
    and_reduce_sequencer #(.PORT_NUM(8), .WIDTH(7)) u1 (.clk(clk), .rst(rst), .bus(i1));
    and_reduce_sequencer #(.PORT_NUM(1), .WIDTH(1)) u2 (.clk(clk), .rst(rst), .bus(i2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    // Monitor step: latency on out_valid rise, result on handshake,
    // in_ready one cycle after the handshake.
    task automatic mon(input int id, input logic ov, input logic ordy, input logic irdy,
                       input logic [31:0] qv, input logic [31:0] bv);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (qsize(id) > 0) begin
            have = 1'b1;
            case (id)
                0:       e = sb0[0];
                1:       e = sb1[0];
                default: e = sb2[0];
            endcase
        end
        if (post_hs[id]) begin
            chk($sformatf("in_ready_after_hs_u%0d", id), 32'(irdy), 1);
            post_hs[id] = 1'b0;
        end
        if (ov && !ov_prev[id]) begin
            if (have) chk($sformatf("latency_u%0d", id), cyc - e.k, e.beats);
            else      chk($sformatf("unexpected_out_valid_u%0d", id), 32'(ov), 0);
        end
        if (ov && ordy && have) begin
            chk($sformatf("q_u%0d", id), qv, e.q);
            chk($sformatf("beats_u%0d", id), bv, e.beats);
            case (id)
                0:       void'(sb0.pop_front());
                1:       void'(sb1.pop_front());
                default: void'(sb2.pop_front());
            endcase
            post_hs[id] = 1'b1;
        end
        ov_prev[id] = ov;
    endtask

    always @(negedge clk) mon(0, i0.out_valid, i0.out_ready, i0.in_ready, 32'(i0.q), 32'(i0.beats));
    always @(negedge clk) mon(1, i1.out_valid, i1.out_ready, i1.in_ready, 32'(i1.q), 32'(i1.beats));
    always @(negedge clk) mon(2, i2.out_valid, i2.out_ready, i2.in_ready, 32'(i2.q), 32'(i2.beats));

    // Stimulus tasks: called at posedge+1, return at posedge+1 after the accept edge.
    task automatic send0(input ops_t op, input int eq, input int eb);
        int n;
        i0.a = op[0]; i0.b = op[1]; i0.c = op[2]; i0.d = op[3];
        i0.e = op[4]; i0.f = op[5]; i0.g = op[6]; i0.h = op[7];
        i0.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!i0.in_ready && n < 40) begin @(negedge clk); n++; end
        chk("accept_wait_u0", 32'(i0.in_ready), 1);
        @(posedge clk);
        sb0.push_back(exp_t'{q: eq, beats: eb, k: cyc + 1});
        #1 i0.in_valid = 1'b0;
    endtask

    task automatic send1(input ops_t op, input int eq, input int eb);
        int n;
        i1.a = op[0]; i1.b = op[1]; i1.c = op[2]; i1.d = op[3];
        i1.e = op[4]; i1.f = op[5]; i1.g = op[6]; i1.h = op[7];
        i1.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!i1.in_ready && n < 40) begin @(negedge clk); n++; end
        chk("accept_wait_u1", 32'(i1.in_ready), 1);
        @(posedge clk);
        sb1.push_back(exp_t'{q: eq, beats: eb, k: cyc + 1});
        acc1.push_back(cyc + 1);
        #1;
    endtask

    task automatic send2(input ops_t op, input int eq, input int eb);
        int n;
        logic [6:0] v;
        v = op[0]; i2.a = v[0]; v = op[1]; i2.b = v[0];
        v = op[2]; i2.c = v[0]; v = op[3]; i2.d = v[0];
        v = op[4]; i2.e = v[0]; v = op[5]; i2.f = v[0];
        v = op[6]; i2.g = v[0]; v = op[7]; i2.h = v[0];
        i2.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!i2.in_ready && n < 40) begin @(negedge clk); n++; end
        chk("accept_wait_u2", 32'(i2.in_ready), 1);
        @(posedge clk);
        sb2.push_back(exp_t'{q: eq, beats: eb, k: cyc + 1});
        #1 i2.in_valid = 1'b0;
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (qsize(id) > 0 && n < 100) begin @(negedge clk); n++; end
        chk($sformatf("drain_u%0d", id), qsize(id), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        ops_t op;
        i0.in_valid = 1'b0; i0.out_ready = 1'b1;
        i0.a = '0; i0.b = '0; i0.c = '0; i0.d = '0; i0.e = '0; i0.f = '0; i0.g = '0; i0.h = '0;
        i1.in_valid = 1'b0; i1.out_ready = 1'b1;
        i1.a = '0; i1.b = '0; i1.c = '0; i1.d = '0; i1.e = '0; i1.f = '0; i1.g = '0; i1.h = '0;
        i2.in_valid = 1'b0; i2.out_ready = 1'b1;
        i2.a = '0; i2.b = '0; i2.c = '0; i2.d = '0; i2.e = '0; i2.f = '0; i2.g = '0; i2.h = '0;

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(i0.out_valid), 0);
        chk("rst_q", 32'(i0.q), 0);
        chk("rst_busy", 32'(i0.busy), 0);
        chk("rst_beats", 32'(i0.beats), 0);
        chk("rst_in_ready", 32'(i0.in_ready), 1);
        chk("rst_u1_beats", 32'(i1.beats), 0);
        chk("rst_u2_out_valid", 32'(i2.out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // u0: all ones, h clears one bit, a all zero
        op = '{default: 7'h7F};
        send0(op, 1, 4);
        drain(0);
        op = '{default: 7'h7F}; op[7] = 7'h7E;
        send0(op, 0, 4);
        drain(0);
        op = '{default: 7'h7F}; op[0] = 7'h00;
        send0(op, 0, EE ? 1 : 4);
        drain(0);

        // u0: backpressure holds DONE while inputs wiggle
        i0.out_ready = 1'b0;
        op = '{default: 7'h7F};
        send0(op, 1, 4);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!i0.out_valid && n < 20) begin @(negedge clk); n++; end
            chk("bp_reach_done", 32'(i0.out_valid), 1);
        end
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_q", 32'(i0.q), 1);
            chk("bp_out_valid", 32'(i0.out_valid), 1);
            chk("bp_in_ready", 32'(i0.in_ready), 0);
            chk("bp_beats", 32'(i0.beats), 4);
            chk("bp_busy", 32'(i0.busy), 1);
            @(posedge clk); #1;
            i0.a = 7'($urandom); i0.b = 7'($urandom); i0.c = 7'($urandom); i0.d = 7'($urandom);
            i0.e = 7'($urandom); i0.f = 7'($urandom); i0.g = 7'($urandom); i0.h = 7'($urandom);
            i0.in_valid = ~i0.in_valid;
        end
        i0.in_valid  = 1'b0;
        i0.out_ready = 1'b1;
        drain(0);
        chk("bp_idle_busy", 32'(i0.busy), 0);

        // u0: reset during RUN drops the job
        op = '{default: 7'h7F};
        send0(op, 1, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        sb0.delete();
        #1;
        chk("midrst_out_valid", 32'(i0.out_valid), 0);
        chk("midrst_q", 32'(i0.q), 0);
        chk("midrst_busy", 32'(i0.busy), 0);
        chk("midrst_beats", 32'(i0.beats), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_no_result", 32'(i0.out_valid), 0);
        @(posedge clk); #1;
        op = '{default: 7'h7F};
        send0(op, 1, 4);
        drain(0);

        // u1: three back-to-back single-beat jobs
        op = '{default: 7'h7F};
        send1(op, 1, 1);
        op[1] = 7'h3F;
        send1(op, 0, 1);
        op = '{default: 7'h7F};
        send1(op, 1, 1);
        i1.in_valid = 1'b0;
        drain(1);
        chk("u1_accept_count", acc1.size(), 3);
        if (acc1.size() == 3) begin
            chk("u1_spacing_1_2", acc1[1] - acc1[0], 3);
            chk("u1_spacing_2_3", acc1[2] - acc1[1], 3);
        end

        // u2: single-lane, single-bit operands
        op = '{default: 7'h01}; op[7] = 7'h00;
        send2(op, 0, 8);
        drain(2);
        op = '{default: 7'h01};
        send2(op, 1, 8);
        drain(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/and_reduce_sequencer.md
Name: and_reduce_sequencer

Overview:
- Multi-cycle controller for the 8-operand AND-reduction datapath (operands a..h, WIDTH bits each).
- Reuses one PORT_NUM-lane reduction slice: captures a job, feeds PORT_NUM operands per beat, accumulates, and returns the result.
- Valid/ready on both sides; one job in flight. Sits between the operand producer and the result consumer.

Parameters:
- PORT_NUM, 2, operands reduced per beat; legal values 1, 2, 4, 8; any other value is an elaboration error.
- WIDTH, 8, operand and result width; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  job offered.
- in_ready  output  1  job accepted when in_valid && in_ready.
- a, b, c, d, e, f, g, h  input  WIDTH each  operands; sampled only on the accept edge.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- q  output  WIDTH  result: bit0 = AND of every bit of a..h; bits WIDTH-1:1 = 0.
- busy  output  1  high in RUN or DONE.
- beats  output  4  number of RUN beats used by the last completed job.

Behaviour:
- BEATS = 8/PORT_NUM.
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: out_valid=0, q=0, busy=0, beats=0, beat counter=0, accumulator=1, operand registers=0.
- in_ready=1 only in IDLE. It is combinational from state.
- IDLE:
  - On accept, register a..h as slots 0..7, set acc=1, cnt=0, and go to RUN.
  - in_valid without acceptance has no effect.
- RUN, one beat per cycle:
  - acc <= acc & (AND of all bits of slots cnt*PORT_NUM .. cnt*PORT_NUM+PORT_NUM-1).
  - cnt <= cnt+1.
  - On the beat where cnt==BEATS-1: load q with the final acc in bit0 (upper bits 0), set beats=cnt+1, and go to DONE.
- DONE:
  - out_valid=1. q is stable until the handshake.
  - On out_valid && out_ready, go to IDLE and clear out_valid. q holds its last value.
- Latency: if accepted at edge k, out_valid rises at edge k+BEATS+... — precisely, RUN occupies edges k+1..k+BEATS, so out_valid is high from edge k+BEATS.
- Back-to-back jobs: in_ready returns in the cycle after the output handshake. No accept in the same cycle as the output handshake; minimum job period is BEATS+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely. q, out_valid and beats are frozen, and in_ready stays 0.
- Reset mid-operation (RUN or DONE): the job is dropped, all reset values apply immediately, and no partial result is emitted.
- Input changes outside the accept edge do not affect the result.
- PORT_NUM=8: a single RUN beat; beats=1.
- WIDTH=1: q is the single result bit.

Optional Feature:
- Macro: AND_REDUCE_EARLY_EXIT_EN.
- Defined:
  - On a RUN beat where the new acc is 0, go directly to DONE with q=0 and beats=cnt+1.
  - Remaining slots are skipped, so latency is data-dependent (minimum 1 beat).
- Undefined: always BEATS beats. beats always equals BEATS after a job.

Decomposition:
- Package and_reduce_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the function beats_of(PORT_NUM);
  - the legal-PORT_NUM check;
  - the beat-count width constant (4).
- One sub-module, and_reduce_lanes: combinational, parameters PORT_NUM and WIDTH. It takes a PORT_NUM*WIDTH flattened slice and produces a 1-bit AND of all its bits.
- The sequencer instantiates it once and drives it with the operand-slot mux selected by cnt.

Test Plan:
- WIDTH=7, PORT_NUM=2, all operands 7'h7F, out_ready=1 → out_valid at edge k+4, q=7'h01, beats=4, in_ready=1 one cycle after the handshake.
- Same setup, h=7'h7E → q=7'h00, beats=4 (macro undefined). With AND_REDUCE_EARLY_EXIT_EN defined and a=7'h00 → q=7'h00, beats=1, out_valid at edge k+1.
- All operands 7'h7F, out_ready held 0 for 5 cycles in DONE; change a..h and toggle in_valid → q=7'h01 stable, in_ready=0, no second accept; release out_ready → IDLE next cycle.
- Assert rst for 1 cycle at the second RUN beat → out_valid=0, q=0, busy=0, beats=0 immediately. A new job of all 7'h7F afterwards gives q=7'h01.
- PORT_NUM=8, WIDTH=7, three back-to-back jobs (all-ones, b=7'h3F, all-ones) with out_ready=1 → results 01, 00, 01 in order, beats=1 each, accepts spaced exactly 3 cycles apart.
- PORT_NUM=1, WIDTH=1, operands 1,1,1,1,1,1,1,0 → q=0 after 8 beats, beats=8.
